// File: rtl/vdp_port_arbiter.sv
// -----------------------------------------------------------------------------
// vdp_port_arbiter
//
// Shares the F18A/TMS9918A CPU port between the Apple II bus and an internal
// host (valid/ready). Apple writes are captured in a one-entry holding
// register and cannot be stalled. Apple reads pass through combinationally.
// Every internal access produces one csw/csr strobe of CSW_CYCLES cycles,
// followed by RECOVERY_CYCLES idle cycles. Host accesses may start only early
// in phi1, so they finish before the Apple can touch the port again.
//
// Ports:
//   clk_logic_i      logic clock (a2bus clk_logic)
//   reset_i          asynchronous active-high reset
//   phi0_i           Apple phi0 level, synchronous to clk_logic_i
//   apple_wr_stb_i   one-cycle pulse: Apple write to the VDP port
//   apple_mode_i     VDP mode bit (addr[0]) for the Apple access
//   apple_data_i     Apple write data
//   apple_rd_i       level: Apple read of the VDP port
//   host_valid_i     host request valid
//   host_ready_o     host request accepted this cycle
//   host_we_i        host access is a write (1) or a read (0)
//   host_mode_i      VDP mode bit for the host access
//   host_data_i      host write data
//   rsp_valid_o      one-cycle pulse: host read data valid
//   rsp_data_o       host read data, held until the next host read
//   vdp_csw_n_o      VDP write strobe (active low)
//   vdp_csr_n_o      VDP read strobe (active low)
//   vdp_mode_o       VDP mode bit
//   vdp_cd_o         VDP write data
//   vdp_cd_i         VDP read data
//   busy_o           arbiter is not idle
//   overrun_o        sticky: an Apple write was overwritten before issue
// -----------------------------------------------------------------------------
module vdp_port_arbiter #(
    parameter int CSW_CYCLES      = 4,
    parameter int RECOVERY_CYCLES = 4,
    parameter int START_GUARD     = 12
) (
    input  logic       clk_logic_i,
    input  logic       reset_i,
    input  logic       phi0_i,
    input  logic       apple_wr_stb_i,
    input  logic       apple_mode_i,
    input  logic [7:0] apple_data_i,
    input  logic       apple_rd_i,
    input  logic       host_valid_i,
    output logic       host_ready_o,
    input  logic       host_we_i,
    input  logic       host_mode_i,
    input  logic [7:0] host_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       vdp_csw_n_o,
    output logic       vdp_csr_n_o,
    output logic       vdp_mode_o,
    output logic [7:0] vdp_cd_o,
    input  logic [7:0] vdp_cd_i,
    output logic       busy_o,
    output logic       overrun_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_A_WR    = 3'd1,
        ST_H_WR    = 3'd2,
        ST_H_RD    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic [7:0] CSW_LAST = 8'(CSW_CYCLES - 1);
    localparam logic [7:0] REC_LAST = 8'(RECOVERY_CYCLES - 1);
    localparam logic [7:0] GUARD    = 8'(START_GUARD);
    localparam logic [7:0] CNT_MAX  = 8'hFF;

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;

    logic       phi0_d_r;
    logic       rd_d_r;
    logic [7:0] phi1_cnt_r;
    logic       pend_r;
    logic       pend_mode_r;
    logic [7:0] pend_data_r;
    logic       overrun_r;

    logic       csw_n_r;
    logic       csr_n_r;
    logic       mode_r;
    logic [7:0] cd_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;

    logic       phi0_fall_s;
    logic       rd_fall_s;
    logic       rd_hold_s;
    logic       idle_s;
    logic [7:0] phi1_pos_s;
    logic       window_s;
    logic       issue_apple_s;
    logic       host_accept_s;
    logic       apple_mode_s;
    logic [7:0] apple_data_s;
    logic       rd_path_s;

    logic       csw_n_nxt_s;
    logic       csr_n_nxt_s;
    logic       mode_nxt_s;
    logic [7:0] cd_nxt_s;
    logic       rsp_valid_nxt_s;
    logic [7:0] rsp_data_nxt_s;

    assign phi0_fall_s = phi0_d_r & ~phi0_i;
    assign rd_fall_s   = rd_d_r & ~apple_rd_i;
    // An Apple read in progress, or the cycle right after it, must not be
    // overlapped by an internal strobe.
    assign rd_hold_s   = apple_rd_i | rd_fall_s;
    assign idle_s      = (state_r == ST_IDLE);

    // Position inside phi1: the falling cycle itself is position 0, so the
    // register holds the position of the following cycle.
    assign phi1_pos_s  = phi0_fall_s ? 8'd0 : phi1_cnt_r;
    assign window_s    = ~phi0_i & (phi1_pos_s < GUARD) & ~apple_rd_i & ~pend_r;

    // A strobe arriving while idle bypasses the holding register so the
    // write strobe starts on the very next cycle.
    assign apple_mode_s  = apple_wr_stb_i ? apple_mode_i : pend_mode_r;
    assign apple_data_s  = apple_wr_stb_i ? apple_data_i : pend_data_r;
    assign issue_apple_s = idle_s & (pend_r | apple_wr_stb_i) & ~rd_hold_s;
    assign host_accept_s = idle_s & ~apple_wr_stb_i & ~rd_fall_s & window_s & host_valid_i;

    assign rd_path_s     = apple_rd_i & (idle_s | (state_r == ST_RECOVER));

    assign host_ready_o  = host_accept_s;
    assign vdp_csw_n_o   = csw_n_r;
    assign vdp_csr_n_o   = csr_n_r & ~rd_path_s;
    assign vdp_mode_o    = rd_path_s ? apple_mode_i : mode_r;
    assign vdp_cd_o      = cd_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_data_o    = rsp_data_r;
    assign busy_o        = ~idle_s;
    assign overrun_o     = overrun_r;

    // Phase tracking, Apple edge history and the Apple write holding register.
    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            phi0_d_r    <= 1'b0;
            rd_d_r      <= 1'b0;
            phi1_cnt_r  <= 8'd0;
            pend_r      <= 1'b0;
            pend_mode_r <= 1'b0;
            pend_data_r <= 8'd0;
            overrun_r   <= 1'b0;
        end else begin
            phi0_d_r <= phi0_i;
            rd_d_r   <= apple_rd_i;
            if (phi0_fall_s) begin
                phi1_cnt_r <= 8'd1;
            end else if (~phi0_i && (phi1_cnt_r != CNT_MAX)) begin
                phi1_cnt_r <= phi1_cnt_r + 8'd1;
            end else begin
                phi1_cnt_r <= phi1_cnt_r;
            end
            if (issue_apple_s) begin
                pend_r <= 1'b0;
            end else if (apple_wr_stb_i) begin
                pend_r      <= 1'b1;
                pend_mode_r <= apple_mode_i;
                pend_data_r <= apple_data_i;
            end else begin
                pend_r <= pend_r;
            end
            // A new strobe while an earlier one is still unissued loses data.
            if (apple_wr_stb_i && pend_r) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // FSM state and cycle counter register.
    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 8'd0;
                if (rd_fall_s) begin
                    next_state_s = ST_RECOVER;
                end else if (issue_apple_s) begin
                    next_state_s = ST_A_WR;
                end else if (host_accept_s) begin
                    next_state_s = host_we_i ? ST_H_WR : ST_H_RD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_A_WR, ST_H_WR, ST_H_RD: begin
                if (cnt_r == CSW_LAST) begin
                    next_state_s = ST_RECOVER;
                    cnt_nxt_s    = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_RECOVER: begin
                // An Apple read inside recovery keeps restarting the gap.
                if (apple_rd_i) begin
                    cnt_nxt_s = 8'd0;
                end else if (cnt_r == REC_LAST) begin
                    next_state_s = ST_IDLE;
                    cnt_nxt_s    = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_nxt_s    = 8'd0;
            end
        endcase
    end

    // Next values of the registered VDP-side and response outputs.
    always_comb begin
        csw_n_nxt_s = ~((next_state_s == ST_A_WR) | (next_state_s == ST_H_WR));
        csr_n_nxt_s = ~(next_state_s == ST_H_RD);
        if (issue_apple_s) begin
            mode_nxt_s = apple_mode_s;
            cd_nxt_s   = apple_data_s;
        end else if (host_accept_s) begin
            mode_nxt_s = host_mode_i;
            cd_nxt_s   = host_data_i;
        end else begin
            mode_nxt_s = mode_r;
            cd_nxt_s   = cd_r;
        end
        // Read data is captured on the last low cycle of csr_n.
        rsp_valid_nxt_s = (state_r == ST_H_RD) && (cnt_r == CSW_LAST);
        if (rsp_valid_nxt_s) begin
            rsp_data_nxt_s = vdp_cd_i;
        end else begin
            rsp_data_nxt_s = rsp_data_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            csw_n_r     <= 1'b1;
            csr_n_r     <= 1'b1;
            mode_r      <= 1'b0;
            cd_r        <= 8'd0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'd0;
        end else begin
            csw_n_r     <= csw_n_nxt_s;
            csr_n_r     <= csr_n_nxt_s;
            mode_r      <= mode_nxt_s;
            cd_r        <= cd_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
        end
    end

endmodule

// File: tb/tb_vdp_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for vdp_port_arbiter. Single accesses come from a vector table;
// collisions, overrun, Apple read and mid-strobe reset are hand sequences.
// A strobe monitor pops expected accesses from a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_vdp_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       phi0;
    logic       apple_wr_stb;
    logic       apple_mode;
    logic [7:0] apple_data;
    logic       apple_rd;
    logic       host_valid;
    logic       host_ready_o;
    logic       host_we;
    logic       host_mode;
    logic [7:0] host_data;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       vdp_csw_n_o;
    logic       vdp_csr_n_o;
    logic       vdp_mode_o;
    logic [7:0] vdp_cd_o;
    logic [7:0] vdp_cd_i;
    logic       busy_o;
    logic       overrun_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         kind;      // 0 apple write, 1 host write, 2 host read
        logic       mode;
        logic [7:0] data;
        logic [7:0] rdata;
        int         exp_first; // cycle after request edge where strobe is first low
        int         exp_low;
        int         exp_busy;
        int         exp_rsp;
    } vec_t;

    typedef struct {
        logic       rd;
        logic       mode;
        logic [7:0] data;
    } exp_t;

    vec_t       vecs[6];
    exp_t       exp_q[$];
    logic [7:0] rsp_q[$];

    vdp_port_arbiter dut (
        .clk_logic_i    (clk),
        .reset_i        (rst),
        .phi0_i         (phi0),
        .apple_wr_stb_i (apple_wr_stb),
        .apple_mode_i   (apple_mode),
        .apple_data_i   (apple_data),
        .apple_rd_i     (apple_rd),
        .host_valid_i   (host_valid),
        .host_ready_o   (host_ready_o),
        .host_we_i      (host_we),
        .host_mode_i    (host_mode),
        .host_data_i    (host_data),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .vdp_csw_n_o    (vdp_csw_n_o),
        .vdp_csr_n_o    (vdp_csr_n_o),
        .vdp_mode_o     (vdp_mode_o),
        .vdp_cd_o       (vdp_cd_o),
        .vdp_cd_i       (vdp_cd_i),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic rd, input logic mode, input logic [7:0] data);
        exp_t e;
        e.rd   = rd;
        e.mode = mode;
        e.data = rd ? 8'h00 : data;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_o; i++) cyc();
        check("wait_idle", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({vdp_csw_n_o, vdp_csr_n_o, vdp_mode_o, vdp_cd_o, host_ready_o,
                         rsp_valid_o, rsp_data_o, busy_o, overrun_o}),
              32'({1'b1, 1'b1, 21'd0}));
    endtask

    // Strobe monitor: measures each csw/csr pulse and checks it against the
    // scoreboard; Apple pass-through reads are not internal accesses.
    logic       in_stb = 1'b0;
    logic       stb_low;
    logic       stb_rd;
    logic       stb_mode;
    logic       stb_unstable;
    logic [7:0] stb_data;
    int         stb_w;
    exp_t       got_e;
    logic [7:0] got_r;

    always @(negedge clk) begin
        stb_low = ~vdp_csw_n_o | (~vdp_csr_n_o & ~apple_rd);
        if (rst) begin
            in_stb = 1'b0;
        end else if (stb_low) begin
            if (!in_stb) begin
                in_stb       = 1'b1;
                stb_w        = 1;
                stb_rd       = ~vdp_csr_n_o;
                stb_mode     = vdp_mode_o;
                stb_data     = vdp_cd_o;
                stb_unstable = 1'b0;
            end else begin
                stb_w++;
                if (vdp_mode_o !== stb_mode || vdp_cd_o !== stb_data) stb_unstable = 1'b1;
            end
        end else if (in_stb) begin
            in_stb = 1'b0;
            // mode/data must still hold one cycle after a write strobe
            if (!stb_rd && (vdp_mode_o !== stb_mode || vdp_cd_o !== stb_data)) stb_unstable = 1'b1;
            check("sb_strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                got_e = exp_q.pop_front();
                check("sb_strobe_access", {22'd0, stb_rd, stb_mode, stb_rd ? 8'h00 : stb_data},
                      {22'd0, got_e.rd, got_e.mode, got_e.data});
            end
            check("sb_strobe_width", stb_w, 32'd4);
            check("sb_strobe_stable", {31'd0, stb_unstable}, 32'd0);
        end
        if (!rst && rsp_valid_o) begin
            check("sb_rsp_expected", {31'd0, rsp_q.size() != 0}, 32'd1);
            if (rsp_q.size() != 0) begin
                got_r = rsp_q.pop_front();
                check("sb_rsp_data", {24'd0, rsp_data_o}, {24'd0, got_r});
            end
        end
    end

    task automatic run_vec(input int idx);
        vec_t v;
        int first, low, busy, rdy, rsp;
        v = vecs[idx];
        wait_idle();
        vdp_cd_i = v.rdata;
        if (v.kind == 0) begin
            apple_mode   = v.mode;
            apple_data   = v.data;
            apple_wr_stb = 1'b1;
            push_exp(1'b0, v.mode, v.data);
            cyc();
            apple_wr_stb = 1'b0;
        end else begin
            phi0       = 1'b1;
            host_valid = 1'b1;
            host_we    = (v.kind == 1);
            host_mode  = v.mode;
            host_data  = v.data;
            for (int i = 0; i < 2; i++) begin
                #1;
                check("vec_ready_in_phi0", {31'd0, host_ready_o}, 32'd0);
                cyc();
            end
            phi0 = 1'b0;
            #1;
            check("vec_ready_first_phi1", {31'd0, host_ready_o}, 32'd1);
            push_exp(v.kind == 2, v.mode, v.data);
            if (v.kind == 2) rsp_q.push_back(v.rdata);
            cyc();
            host_valid = 1'b0;
        end
        first = 0; low = 0; busy = 0; rdy = 0; rsp = 0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (!vdp_csw_n_o || !vdp_csr_n_o) begin
                low++;
                if (first == 0) first = c;
            end
            if (busy_o) busy++;
            if (host_ready_o) rdy++;
            if (rsp_valid_o) rsp++;
            cyc();
        end
        check("vec_first_low_cycle", first, v.exp_first);
        check("vec_low_cycles", low, v.exp_low);
        check("vec_busy_cycles", busy, v.exp_busy);
        check("vec_ready_while_busy", rdy, 32'd0);
        check("vec_rsp_pulses", rsp, v.exp_rsp);
        if (v.kind == 2) check("vec_rsp_hold", {24'd0, rsp_data_o}, {24'd0, v.rdata});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cnt;
        rst = 1'b1; phi0 = 1'b1; apple_wr_stb = 1'b0; apple_mode = 1'b0;
        apple_data = 8'h00; apple_rd = 1'b0; host_valid = 1'b0; host_we = 1'b0;
        host_mode = 1'b0; host_data = 8'h00; vdp_cd_i = 8'h00;

        vecs[0] = '{0, 1'b1, 8'h87, 8'h00, 1, 4, 8, 0};
        vecs[1] = '{1, 1'b0, 8'h5A, 8'h00, 1, 4, 8, 0};
        vecs[2] = '{2, 1'b1, 8'h00, 8'hC3, 1, 4, 8, 1};
        vecs[3] = '{0, 1'b0, 8'h3C, 8'h11, 1, 4, 8, 0};
        vecs[4] = '{1, 1'b1, 8'hA5, 8'h22, 1, 4, 8, 0};
        vecs[5] = '{2, 1'b0, 8'h00, 8'h5E, 1, 4, 8, 1};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #3 rst = 1'b0;
        cyc();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Apple write and host request eligible together; host may follow only
        // if recovery ends inside the start window (position 11 ok, 12 not).
        for (int p = 2; p <= 3; p++) begin
            wait_idle();
            phi0 = 1'b1;
            cyc();
            phi0 = 1'b0;
            repeat (p) cyc();
            host_valid = 1'b1; host_we = 1'b1; host_mode = 1'b1; host_data = 8'(8'h30 + p);
            apple_wr_stb = 1'b1; apple_mode = 1'b0; apple_data = 8'(8'h40 + p);
            push_exp(1'b0, 1'b0, 8'(8'h40 + p));
            #1;
            check("collide_ready", {31'd0, host_ready_o}, 32'd0);
            cyc();
            apple_wr_stb = 1'b0;
            acc = 0;
            for (int c = 1; c <= 14; c++) begin
                #1;
                if (host_valid && host_ready_o) begin
                    acc = c;
                    push_exp(1'b0, 1'b1, 8'(8'h30 + p));
                end
                cyc();
                if (acc != 0) host_valid = 1'b0;
            end
            check("collide_accept_cycle", acc, (p == 2) ? 32'd9 : 32'd0);
            if (acc == 0) begin
                phi0 = 1'b1;
                cyc();
                phi0 = 1'b0;
                #1;
                check("collide_next_phi1", {31'd0, host_ready_o}, 32'd1);
                push_exp(1'b0, 1'b1, 8'(8'h30 + p));
                cyc();
                host_valid = 1'b0;
            end
        end

        // Two Apple writes during one host write: only the second survives.
        wait_idle();
        phi0 = 1'b1;
        cyc();
        host_valid = 1'b1; host_we = 1'b1; host_mode = 1'b0; host_data = 8'h66;
        phi0 = 1'b0;
        #1;
        check("ovr_host_accept", {31'd0, host_ready_o}, 32'd1);
        push_exp(1'b0, 1'b0, 8'h66);
        cyc();
        host_valid = 1'b0;
        apple_wr_stb = 1'b1; apple_mode = 1'b1; apple_data = 8'h11;
        cyc();
        apple_wr_stb = 1'b0;
        #1;
        check("ovr_after_first", {31'd0, overrun_o}, 32'd0);
        cyc();
        apple_wr_stb = 1'b1; apple_data = 8'h22;
        cyc();
        apple_wr_stb = 1'b0;
        push_exp(1'b0, 1'b1, 8'h22);
        #1;
        check("ovr_after_second", {31'd0, overrun_o}, 32'd1);
        repeat (20) cyc();
        check("ovr_sb_empty", exp_q.size(), 32'd0);

        // Apple read: combinational csr/mode, then recovery after it ends.
        wait_idle();
        apple_mode = 1'b1;
        apple_rd   = 1'b1;
        #1;
        check("ard_comb", {30'd0, vdp_csr_n_o, vdp_mode_o}, 32'd1);
        cyc();
        cyc();
        apple_rd   = 1'b0;
        apple_mode = 1'b0;
        cyc();
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (busy_o) cnt++;
            cyc();
        end
        check("ard_recover_len", cnt, 32'd4);
        check("sb_drained", exp_q.size() + rsp_q.size(), 32'd0);

        // Reset in the middle of an Apple write with another write pending.
        wait_idle();
        apple_wr_stb = 1'b1; apple_mode = 1'b1; apple_data = 8'hAA;
        push_exp(1'b0, 1'b1, 8'hAA);
        cyc();
        apple_wr_stb = 1'b0;
        cyc();
        apple_wr_stb = 1'b1; apple_data = 8'hBB;
        cyc();
        apple_wr_stb = 1'b0;
        #1;
        check("rst_pre_csw_low", {31'd0, vdp_csw_n_o}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_csw", {31'd0, vdp_csw_n_o}, 32'd1);
        check_reset_outputs("rst_mid_outputs");
        @(posedge clk);
        #3 rst = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (busy_o || !vdp_csw_n_o) cnt++;
        end
        check("rst_pend_cleared", cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
